// File: rtl/alu_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_share_ctrl : round-robin sequencer sharing one 32-bit ALU between    |
// |                  two requesters, with held response and HI/LO registers. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_share_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter logic [3:0]  MUL_OP      = 4'd3,
  parameter logic [3:0]  DIV_OP      = 4'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [3:0]  req0_s,
  input  logic [3:0]  req1_s,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic [31:0] resp_result2,
  output logic        resp_equal,
  output logic        resp_overflow,
  output logic        resp_uof,
  output logic [3:0]  alu_s,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_result2,
  input  logic        alu_equal,
  input  logic        alu_overflow,
  input  logic        alu_uof,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        id_q, id_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  alu_s_q, alu_s_d;
  logic [31:0] alu_x_q, alu_x_d;
  logic [31:0] alu_y_q, alu_y_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [31:0] resp_result_q, resp_result_d;
  logic [31:0] resp_result2_q, resp_result2_d;
  logic        resp_equal_q, resp_equal_d;
  logic        resp_overflow_q, resp_overflow_d;
  logic        resp_uof_q, resp_uof_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic grant_valid;
  logic grant_id;

  // On contention the requester that did not win last time is served.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  end

  assign req0_ready = (state_q == IDLE) & grant_valid & ~grant_id;
  assign req1_ready = (state_q == IDLE) & grant_valid & grant_id;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    id_d            = id_q;
    cnt_d           = cnt_q;
    alu_s_d         = alu_s_q;
    alu_x_d         = alu_x_q;
    alu_y_d         = alu_y_q;
    resp_valid_d    = resp_valid_q;
    resp_id_d       = resp_id_q;
    resp_result_d   = resp_result_q;
    resp_result2_d  = resp_result2_q;
    resp_equal_d    = resp_equal_q;
    resp_overflow_d = resp_overflow_q;
    resp_uof_d      = resp_uof_q;
    hi_d            = hi_q;
    lo_d            = lo_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d      = EXEC;
          id_d         = grant_id;
          last_grant_d = grant_id;
          cnt_d        = EXEC_LOAD;
          alu_s_d      = grant_id ? req1_s : req0_s;
          alu_x_d      = grant_id ? req1_x : req0_x;
          alu_y_d      = grant_id ? req1_y : req0_y;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d         = RESP;
          resp_valid_d    = 1'b1;
          resp_id_d       = id_q;
          resp_result_d   = alu_result;
          resp_result2_d  = alu_result2;
          resp_equal_d    = alu_equal;
          resp_overflow_d = alu_overflow;
          resp_uof_d      = alu_uof;
          if ((alu_s_q == MUL_OP) || (alu_s_q == DIV_OP)) begin
            lo_d = alu_result;
            hi_d = alu_result2;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // Response is released here; a new grant waits for the IDLE cycle.
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      id_q            <= 1'b0;
      cnt_q           <= 4'd0;
      alu_s_q         <= 4'd0;
      alu_x_q         <= 32'd0;
      alu_y_q         <= 32'd0;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= 1'b0;
      resp_result_q   <= 32'd0;
      resp_result2_q  <= 32'd0;
      resp_equal_q    <= 1'b0;
      resp_overflow_q <= 1'b0;
      resp_uof_q      <= 1'b0;
      hi_q            <= 32'd0;
      lo_q            <= 32'd0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      id_q            <= id_d;
      cnt_q           <= cnt_d;
      alu_s_q         <= alu_s_d;
      alu_x_q         <= alu_x_d;
      alu_y_q         <= alu_y_d;
      resp_valid_q    <= resp_valid_d;
      resp_id_q       <= resp_id_d;
      resp_result_q   <= resp_result_d;
      resp_result2_q  <= resp_result2_d;
      resp_equal_q    <= resp_equal_d;
      resp_overflow_q <= resp_overflow_d;
      resp_uof_q      <= resp_uof_d;
      hi_q            <= hi_d;
      lo_q            <= lo_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_result   = resp_result_q;
  assign resp_result2  = resp_result2_q;
  assign resp_equal    = resp_equal_q;
  assign resp_overflow = resp_overflow_q;
  assign resp_uof      = resp_uof_q;
  assign alu_s         = alu_s_q;
  assign alu_x         = alu_x_q;
  assign alu_y         = alu_y_q;
  assign hi            = hi_q;
  assign lo            = lo_q;
  assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire
